// File: rtl/dmx4_deser_if.sv
`timescale 1ns/1ps
`default_nettype none
//------------------------------------------------------------------------------
// Module      : dmx4_deser_if
// Description : Bus bundle for the dmx4_deser 1:4 word deserializer.
//               Carries the input word stream (valid/ready), the assembled
//               4-lane output frame (valid/ready), and the lane select.
//               With DMX4_FLUSH_EN defined it also carries flush/out_mask.
//               master : the side that feeds words and consumes frames
//               slave  : the deserializer itself
// Ports       : in_valid, in_ready, d_in[W-1:0], out_valid, out_ready,
//               y0..y3[W-1:0], sel[1:0], flush, out_mask[3:0] (flush build)
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
interface dmx4_deser_if #(
   parameter int W = 8
);
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] d_in;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] y0;
   logic [W-1:0] y1;
   logic [W-1:0] y2;
   logic [W-1:0] y3;
   logic [1:0]   sel;
`ifdef DMX4_FLUSH_EN
   logic         flush;
   logic [3:0]   out_mask;

   modport master (
      output in_valid, d_in, out_ready, flush,
      input  in_ready, out_valid, y0, y1, y2, y3, sel, out_mask
   );
   modport slave (
      input  in_valid, d_in, out_ready, flush,
      output in_ready, out_valid, y0, y1, y2, y3, sel, out_mask
   );
`else
   modport master (
      output in_valid, d_in, out_ready,
      input  in_ready, out_valid, y0, y1, y2, y3, sel
   );
   modport slave (
      input  in_valid, d_in, out_ready,
      output in_ready, out_valid, y0, y1, y2, y3, sel
   );
`endif
endinterface
`default_nettype wire

// File: rtl/dmx4_deser.sv
`timescale 1ns/1ps
`default_nettype none
//------------------------------------------------------------------------------
// Module      : dmx4_deser
// Description : 1:4 word deserializer. Successive accepted words are written
//               to lanes y0..y3 under a rotating 2-bit select; once all four
//               lanes are written the frame is presented with out_valid.
//               A frame release and a new word may coincide (no bubble).
//               Optional feature macro: DMX4_FLUSH_EN (partial-frame flush
//               with out_mask reporting which lanes carry data).
// Ports       : clk      - rising-edge clock
//               reset_n  - asynchronous active-low reset
//               bus      - dmx4_deser_if.slave (word input, frame output, sel)
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module dmx4_deser #(
   parameter int W = 8
) (
   input  wire logic   clk,
   input  wire logic   reset_n,
   dmx4_deser_if.slave bus
);

   typedef enum logic {
      FILL = 1'b0,
      FULL = 1'b1
   } state_t;

   state_t       r_state;
   logic [1:0]   r_sel;
   logic [W-1:0] r_lane [4];
   logic         r_out_valid;
   logic         w_in_ready;
   logic         w_in_fire;

`ifdef DMX4_FLUSH_EN
   logic [3:0]   r_mask;
   logic [2:0]   w_fill;       // lanes written once this cycle's word lands
   logic [3:0]   w_fill_mask;

   assign w_fill = {1'b0, r_sel} + {2'b00, w_in_fire};

   always_comb begin
      w_fill_mask = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         w_fill_mask[i] = (3'(i) < w_fill);
      end
   end
`endif

   // In FULL the frame slot frees up exactly when the consumer takes it,
   // so input readiness follows out_ready combinationally.
   assign w_in_ready = (r_state == FILL) ? 1'b1 : bus.out_ready;
   assign w_in_fire  = bus.in_valid & w_in_ready;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= FILL;
         r_sel       <= 2'd0;
         r_out_valid <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            r_lane[i] <= '0;
         end
`ifdef DMX4_FLUSH_EN
         r_mask      <= 4'b0000;
`endif
      end else begin
         case (r_state)
            FILL: begin
               if (w_in_fire) begin
                  r_lane[r_sel] <= bus.d_in;
                  r_sel         <= r_sel + 2'd1;
`ifdef DMX4_FLUSH_EN
                  r_mask[r_sel] <= 1'b1;
`endif
                  if (r_sel == 2'd3) begin
                     r_state     <= FULL;
                     r_out_valid <= 1'b1;
                  end
               end
`ifdef DMX4_FLUSH_EN
               // Close a partial frame: any word arriving this cycle is
               // kept, lanes beyond it are zeroed. The later assignments
               // here deliberately override the accept path above.
               if (bus.flush && (r_sel != 2'd0)) begin
                  r_state     <= FULL;
                  r_out_valid <= 1'b1;
                  r_sel       <= 2'd0;
                  r_mask      <= w_fill_mask;
                  for (int i = 0; i < 4; i++) begin
                     if (!w_fill_mask[i]) begin
                        r_lane[i] <= '0;
                     end
                  end
               end
`endif
            end
            FULL: begin
               if (bus.out_ready) begin
                  r_state     <= FILL;
                  r_out_valid <= 1'b0;
                  if (bus.in_valid) begin
                     // Frame leaves and the next frame's first word lands
                     // in the same cycle.
                     r_lane[0] <= bus.d_in;
                     r_sel     <= 2'd1;
`ifdef DMX4_FLUSH_EN
                     r_mask    <= 4'b0001;
`endif
                  end else begin
                     r_sel     <= 2'd0;
`ifdef DMX4_FLUSH_EN
                     r_mask    <= 4'b0000;
`endif
                  end
               end
            end
            default: begin
               r_state <= FILL;
            end
         endcase
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.sel       = r_sel;
   assign bus.y0        = r_lane[0];
   assign bus.y1        = r_lane[1];
   assign bus.y2        = r_lane[2];
   assign bus.y3        = r_lane[3];
`ifdef DMX4_FLUSH_EN
   assign bus.out_mask  = r_mask;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dmx4_deser.sv
`timescale 1ns/1ps
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_dmx4_deser
// Description : Directed self-checking bench for dmx4_deser. Covers reset,
//               a basic frame, backpressure, back-to-back frames, input gaps
//               and (with DMX4_FLUSH_EN) partial-frame flush.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_dmx4_deser;
   localparam int W = 8;

   logic clk     = 1'b0;
   logic reset_n = 1'b0;
   int   tests   = 0;
   int   fails   = 0;

   dmx4_deser_if #(.W(W)) bus ();

   dmx4_deser #(.W(W)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   wire [W-1:0] y_obs [4];
   assign y_obs[0] = bus.y0;
   assign y_obs[1] = bus.y1;
   assign y_obs[2] = bus.y2;
   assign y_obs[3] = bus.y3;

   // Advance one clock; leaves time 1ns after the active edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      reset_n = 1'b0;
      #2;
      reset_n = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      logic [W-1:0] e [4];
      e = '{8'h00, 8'h00, 8'h00, 8'h00};
      #12;
      tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid got=%0b exp=0", bus.out_valid); end
      tests++; if (bus.sel !== 2'd0) begin fails++; $display("FAIL rst_sel got=%0d exp=0", bus.sel); end
      reset_n = 1'b1;
      tick();
      tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL rst_in_ready got=%0b exp=1", bus.in_ready); end
      // two words mid-stream, then asynchronous reset between edges
      bus.in_valid = 1'b1; bus.d_in = 8'h77; tick();
      bus.d_in = 8'h88; tick();
      bus.in_valid = 1'b0;
      tests++; if (bus.sel !== 2'd2) begin fails++; $display("FAIL pre_rst_sel got=%0d exp=2", bus.sel); end
      tests++; if (bus.y1 !== 8'h88) begin fails++; $display("FAIL pre_rst_y1 got=%0h exp=88", bus.y1); end
      #2 reset_n = 1'b0;
      #1;
      for (int i = 0; i < 4; i++) begin
         tests++; if (y_obs[i] !== e[i]) begin fails++; $display("FAIL async_rst_y%0d got=%0h exp=%0h", i, y_obs[i], e[i]); end
      end
      tests++; if (bus.sel !== 2'd0) begin fails++; $display("FAIL async_rst_sel got=%0d exp=0", bus.sel); end
      tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL async_rst_out_valid got=%0b exp=0", bus.out_valid); end
      #1 reset_n = 1'b1;
      tick();
      tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL post_rst_in_ready got=%0b exp=1", bus.in_ready); end
   endtask

   task automatic test_basic_frame();
      logic [W-1:0] w [4];
      w = '{8'h11, 8'h22, 8'h33, 8'h44};
      bus.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus.in_valid = 1'b1; bus.d_in = w[i];
         tick();
         if (i == 2) begin
            tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL basic_early_valid got=%0b exp=0", bus.out_valid); end
         end
      end
      bus.in_valid = 1'b0;
      tests++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL basic_out_valid got=%0b exp=1", bus.out_valid); end
      for (int i = 0; i < 4; i++) begin
         tests++; if (y_obs[i] !== w[i]) begin fails++; $display("FAIL basic_y%0d got=%0h exp=%0h", i, y_obs[i], w[i]); end
      end
      tests++; if (bus.sel !== 2'd0) begin fails++; $display("FAIL basic_sel got=%0d exp=0", bus.sel); end
      tick();
      tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL basic_release got=%0b exp=0", bus.out_valid); end
      tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL basic_fill_ready got=%0b exp=1", bus.in_ready); end
   endtask

   task automatic test_backpressure();
      logic [W-1:0] w [4];
      w = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
      bus.out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         bus.in_valid = 1'b1; bus.d_in = w[i];
         tick();
      end
      bus.d_in = 8'hEE;
      for (int c = 0; c < 5; c++) begin
         tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready c%0d got=%0b exp=0", c, bus.in_ready); end
         tick();
         tests++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL bp_out_valid c%0d got=%0b exp=1", c, bus.out_valid); end
         tests++; if (bus.sel !== 2'd0) begin fails++; $display("FAIL bp_sel c%0d got=%0d exp=0", c, bus.sel); end
         for (int i = 0; i < 4; i++) begin
            tests++; if (y_obs[i] !== w[i]) begin fails++; $display("FAIL bp_y%0d c%0d got=%0h exp=%0h", i, c, y_obs[i], w[i]); end
         end
      end
      bus.out_ready = 1'b1;
      #1;
      tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL bp_release_ready got=%0b exp=1", bus.in_ready); end
      tick();
      bus.in_valid = 1'b0;
      tests++; if (bus.y0 !== 8'hEE) begin fails++; $display("FAIL bp_y0_new got=%0h exp=ee", bus.y0); end
      tests++; if (bus.sel !== 2'd1) begin fails++; $display("FAIL bp_sel_new got=%0d exp=1", bus.sel); end
      tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL bp_out_valid_new got=%0b exp=0", bus.out_valid); end
   endtask

   task automatic test_back_to_back();
      apply_reset();
      bus.out_ready = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         bus.in_valid = 1'b1; bus.d_in = 8'(k);
         #1;
         tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL b2b_in_ready k%0d got=%0b exp=1", k, bus.in_ready); end
         tick();
         if (k == 4 || k == 8) begin
            tests++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL b2b_out_valid k%0d got=%0b exp=1", k, bus.out_valid); end
            for (int i = 0; i < 4; i++) begin
               tests++; if (y_obs[i] !== 8'(k - 3 + i)) begin fails++; $display("FAIL b2b_y%0d k%0d got=%0h exp=%0h", i, k, y_obs[i], 8'(k - 3 + i)); end
            end
         end
         if (k == 5) begin
            tests++; if (bus.out_valid !== 1'b0 || bus.sel !== 2'd1) begin fails++; $display("FAIL b2b_overlap got valid=%0b sel=%0d exp valid=0 sel=1", bus.out_valid, bus.sel); end
         end
      end
      bus.in_valid = 1'b0;
      tick();
   endtask

   task automatic test_gaps();
      logic       v   [7];
      logic [1:0] es  [7];
      logic [W-1:0] w [4];
      int n;
      v  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      es = '{2'd1, 2'd1, 2'd1, 2'd2, 2'd3, 2'd3, 2'd0};
      w  = '{8'h10, 8'h20, 8'h30, 8'h40};
      n = 0;
      bus.out_ready = 1'b0;
      tests++; if (bus.sel !== 2'd0) begin fails++; $display("FAIL gap_sel_start got=%0d exp=0", bus.sel); end
      for (int c = 0; c < 7; c++) begin
         bus.in_valid = v[c];
         bus.d_in = v[c] ? w[n] : 8'hFF;
         if (v[c]) n++;
         tick();
         tests++; if (bus.sel !== es[c]) begin fails++; $display("FAIL gap_sel c%0d got=%0d exp=%0d", c, bus.sel, es[c]); end
      end
      bus.in_valid = 1'b0;
      tests++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL gap_out_valid got=%0b exp=1", bus.out_valid); end
      for (int i = 0; i < 4; i++) begin
         tests++; if (y_obs[i] !== w[i]) begin fails++; $display("FAIL gap_y%0d got=%0h exp=%0h", i, y_obs[i], w[i]); end
      end
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
   endtask

`ifdef DMX4_FLUSH_EN
   task automatic test_flush();
      // flush with sel=0 is ignored
      bus.flush = 1'b1; tick(); bus.flush = 1'b0;
      tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL flush_sel0 got=%0b exp=0", bus.out_valid); end
      // lanes 2/3 still hold stale 30/40 from the previous frame
      bus.in_valid = 1'b1; bus.d_in = 8'h5A; tick();
      bus.d_in = 8'h6B; tick();
      bus.in_valid = 1'b0; bus.flush = 1'b1; tick();
      bus.flush = 1'b0;
      tests++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL flush_out_valid got=%0b exp=1", bus.out_valid); end
      tests++; if (bus.out_mask !== 4'b0011) begin fails++; $display("FAIL flush_mask got=%b exp=0011", bus.out_mask); end
      tests++; if (bus.y0 !== 8'h5A || bus.y1 !== 8'h6B) begin fails++; $display("FAIL flush_y01 got=%0h,%0h exp=5a,6b", bus.y0, bus.y1); end
      tests++; if (bus.y2 !== 8'h00 || bus.y3 !== 8'h00) begin fails++; $display("FAIL flush_y23 got=%0h,%0h exp=0,0", bus.y2, bus.y3); end
      tests++; if (bus.sel !== 2'd0) begin fails++; $display("FAIL flush_sel got=%0d exp=0", bus.sel); end
      bus.out_ready = 1'b1; tick(); bus.out_ready = 1'b0;
      // flush coinciding with the second word
      bus.in_valid = 1'b1; bus.d_in = 8'h01; tick();
      bus.d_in = 8'h02; bus.flush = 1'b1; tick();
      bus.in_valid = 1'b0; bus.flush = 1'b0;
      tests++; if (bus.out_mask !== 4'b0011) begin fails++; $display("FAIL flushw_mask got=%b exp=0011", bus.out_mask); end
      tests++; if (bus.y1 !== 8'h02 || bus.out_valid !== 1'b1) begin fails++; $display("FAIL flushw_y1 got=%0h valid=%0b exp=02 valid=1", bus.y1, bus.out_valid); end
      bus.out_ready = 1'b1; tick(); bus.out_ready = 1'b0;
      // full frame reports all lanes
      for (int i = 0; i < 4; i++) begin
         bus.in_valid = 1'b1; bus.d_in = 8'(8'hC0 + i); tick();
      end
      bus.in_valid = 1'b0;
      tests++; if (bus.out_mask !== 4'b1111) begin fails++; $display("FAIL full_mask got=%b exp=1111", bus.out_mask); end
      bus.out_ready = 1'b1; tick(); bus.out_ready = 1'b0;
   endtask
`endif

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      bus.in_valid  = 1'b0;
      bus.d_in      = '0;
      bus.out_ready = 1'b0;
`ifdef DMX4_FLUSH_EN
      bus.flush     = 1'b0;
`endif
      test_reset();
      test_basic_frame();
      test_backpressure();
      test_back_to_back();
      test_gaps();
`ifdef DMX4_FLUSH_EN
      test_flush();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
`default_nettype wire
